// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  // Default operand width in bits.
  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder; two of these plus an OR form the serial full adder.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with valid/ready handshakes on operands and result.
// Operands are latched on accept and processed LSB first, one bit per cycle.
// Optional macro SERIAL_SUB_EN adds two's-complement subtraction via op_sub.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             carry_out_q;
  logic             res_valid_q;
  logic             start_ready_q;
  logic             busy_q;

  logic b_bit;
  logic carry_init;
  logic ha0_sum, ha0_carry, ha1_carry;
  logic fa_sum, fa_cout;

`ifdef SERIAL_SUB_EN
  logic sub_q;
  // Subtraction feeds inverted B bits; the preset carry supplies the +1.
  assign b_bit      = b_q[0] ^ sub_q;
  assign carry_init = op_sub;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign b_bit         = b_q[0];
  assign carry_init    = 1'b0;
`endif

  half_adder u_ha0 (
    .a_i     (a_q[0]),
    .b_i     (b_bit),
    .sum_o   (ha0_sum),
    .carry_o (ha0_carry)
  );

  half_adder u_ha1 (
    .a_i     (ha0_sum),
    .b_i     (carry_q),
    .sum_o   (fa_sum),
    .carry_o (ha1_carry)
  );

  assign fa_cout = ha0_carry | ha1_carry;

  // FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      result_q      <= '0;
      carry_q       <= 1'b0;
      carry_out_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start_valid) begin
            a_q           <= op_a;
            b_q           <= op_b;
            carry_q       <= carry_init;
            cnt_q         <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= StRun;
`ifdef SERIAL_SUB_EN
            sub_q         <= op_sub;
`endif
          end
        end
        StRun: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          result_q <= {fa_sum, result_q[WIDTH-1:1]};
          carry_q  <= fa_cout;
          if (cnt_q == LastBit) begin
            carry_out_q <= fa_cout;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          // res_valid lags DONE entry by one cycle; handshake only once it is up.
          if (res_valid_q && res_ready) begin
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
          end else begin
            res_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign result      = result_q;
  assign carry_out   = carry_out_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised self-checking bench for serial_add_ctrl against an arithmetic model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_sub      (op_sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry_out   (carry_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact (W+1)-bit sum; subtraction is A + ~B + 1 when enabled.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    int unsigned s;
    s = int'(a) + int'(b);
`ifdef SERIAL_SUB_EN
    if (sub) s = int'(a) + ((2 ** W - 1) - int'(b)) + 1;
`else
    if (sub) s = int'(a) + int'(b);
`endif
    return s[W:0];
  endfunction

  // One full transaction: offer, time res_valid, hold result, then drain.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input int hold);
    logic [W:0] exp;
    int cyc;
    exp = model(a, b, sub);
    check("start_ready_idle", start_ready, 1);
    start_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    op_sub      = sub;
    @(negedge clk);
    cyc = 0;
    // Inputs wiggle randomly while busy; they must be ignored.
    while (!res_valid && cyc < 40) begin
      check("start_ready_busy", start_ready, 0);
      check("busy_high", busy, 1);
      start_valid = 1'($urandom);
      op_a        = W'($urandom);
      op_b        = W'($urandom);
      op_sub      = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, W + 1);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", res_valid, 1);
      check("hold_result", result, exp[W-1:0]);
      check("hold_carry", carry_out, exp[W]);
      check("hold_ready_low", start_ready, 0);
      @(negedge clk);
    end
    check("result", result, exp[W-1:0]);
    check("carry_out", carry_out, exp[W]);
    check("valid_at_take", res_valid, 1);
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_start_ready", start_ready, 1);
    check("post_busy", busy, 0);
    check("post_res_valid", res_valid, 0);
  endtask

  initial begin
    int seen;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    op_sub      = 1'b0;
    res_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_start_ready", start_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'h5A, 8'h33, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1);
    do_op(8'h12, 8'h34, 1'b0, 5);
    do_op(8'h10, 8'h01, 1'b1, 0);
    do_op(8'h01, 8'h02, 1'b1, 2);

    // Abort mid-RUN with reset; no result may appear afterwards.
    start_valid = 1'b1;
    op_a        = 8'hAA;
    op_b        = 8'h55;
    op_sub      = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_start_ready", start_ready, 1);
    check("abort_res_valid", res_valid, 0);
    check("abort_result", result, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    do_op(8'h01, 8'h01, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
